data_memory_param: RTL and testbench

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

---
 rtl/data_memory_pkg.sv | 12 +
 rtl/mem_array.sv | 27 ++
 rtl/data_memory_param.sv | 116 +++++++++++
 tb/tb_data_memory_param.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared state encoding and read-during-write policy codes
package data_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage: synchronous write, combinational read, no reset
module mem_array #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_C)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH_C) ? mem[raddr] : '0;

endmodule

// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - single-port data memory with power-up clear sweep,
// range checking and selectable read-during-write behaviour
module data_memory_param
    import data_memory_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] M_add,
    input  logic              M_we,
    input  logic              M_re,
    input  logic [DATA_W-1:0] M_wd,
    output logic [DATA_W-1:0] M_rd,
    output logic              M_rvalid,
    output logic              M_ready,
    output logic              M_err
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              in_range;
    logic              ready;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (M_add),
        .rdata (mem_rdata)
    );

    assign in_range = ({1'b0, M_add} < DEPTH_C);
    assign ready    = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = M_add;
        mem_wdata = M_wd;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                mem_we = M_we && in_range;
                err_d  = (M_we || M_re) && !in_range;
                if (M_re) begin
                    rvalid_d = 1'b1;
                    // mem_rdata is still the pre-write word, which gives old-data behaviour
                    if (!in_range) begin
                        rd_d = '0;
                    end else if (RDW_MODE == RDW_NEW && M_we) begin
                        rd_d = M_wd;
                    end else begin
                        rd_d = mem_rdata;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign M_rd     = rd_q;
    assign M_rvalid = rvalid_q;
    assign M_ready  = ready;
    assign M_err    = err_q;

endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - directed bench for data_memory_param in both read-during-write modes
module tb_data_memory_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [3:0] add = '0;
    logic       we  = 1'b0;
    logic       re  = 1'b0;
    logic [7:0] wd  = '0;
    logic [7:0] rd_o, rd_n;
    logic       rv_o, rv_n, rdy_o, rdy_n, err_o, err_n;

    logic [3:0] add4 = '0;
    logic       we4  = 1'b0;
    logic       re4  = 1'b0;
    logic [3:0] wd4  = '0;
    logic [3:0] rd_c, rd_d;
    logic       rv_c, rv_d, rdy_c, rdy_d, err_c, err_d;
    logic       err_cd_seen = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [12];

    always #5 clk = ~clk;

    data_memory_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RDW_MODE(0)) dut_old (
        .clk(clk), .rst(rst), .M_add(add), .M_we(we), .M_re(re), .M_wd(wd),
        .M_rd(rd_o), .M_rvalid(rv_o), .M_ready(rdy_o), .M_err(err_o));

    data_memory_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RDW_MODE(1)) dut_new (
        .clk(clk), .rst(rst), .M_add(add), .M_we(we), .M_re(re), .M_wd(wd),
        .M_rd(rd_n), .M_rvalid(rv_n), .M_ready(rdy_n), .M_err(err_n));

    data_memory_param dut_def_old (
        .clk(clk), .rst(rst), .M_add(add4), .M_we(we4), .M_re(re4), .M_wd(wd4),
        .M_rd(rd_c), .M_rvalid(rv_c), .M_ready(rdy_c), .M_err(err_c));

    data_memory_param #(.RDW_MODE(1)) dut_def_new (
        .clk(clk), .rst(rst), .M_add(add4), .M_we(we4), .M_re(re4), .M_wd(wd4),
        .M_rd(rd_d), .M_rvalid(rv_d), .M_ready(rdy_d), .M_err(err_d));

    always @(negedge clk) begin
        if (err_c || err_d) err_cd_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic read_both(input logic [3:0] a, input logic [7:0] exp, input string tag);
        add = a; we = 1'b0; re = 1'b1;
        cycle();
        check({tag, "_rd_old"}, 32'(rd_o), 32'(exp));
        check({tag, "_rd_new"}, 32'(rd_n), 32'(exp));
        check({tag, "_rv"}, 32'({rv_o, rv_n}), 32'b11);
        idle();
    endtask

    task automatic write_both(input logic [3:0] a, input logic [7:0] d);
        add = a; wd = d; we = 1'b1; re = 1'b0;
        cycle();
        idle();
    endtask

    task automatic wait_ready(input int already, output int n);
        n = already;
        while (!rdy_o && n < 40) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;

        #2;
        check("rst_rd", 32'(rd_o), 32'h0);
        check("rst_flags", 32'({rv_o, rdy_o, err_o, rdy_n}), 32'h0);
        cycle();
        cycle();

        // request in first cycle after release must be ignored
        rst = 1'b1;
        add = 4'd0; wd = 8'h55; we = 1'b1; re = 1'b1;
        cycle();
        check("first_cycle_ignored", 32'({rv_o, err_o, rdy_o}), 32'h0);
        idle();
        wait_ready(1, n);
        check("clear_cycles", 32'(n), 32'd12);
        check("ready_new", 32'(rdy_n), 32'd1);

        for (int a = 0; a < 12; a++) model[a] = 8'h00;
        for (int a = 0; a < 12; a++) read_both(4'(a), 8'h00, "post_clear");

        write_both(4'd3, 8'hA5);
        model[3] = 8'hA5;
        read_both(4'd3, 8'hA5, "rd_a5");
        cycle();
        check("hold_rv", 32'(rv_o), 32'd0);
        check("hold_rd1", 32'(rd_o), 32'hA5);
        cycle();
        check("hold_rd2", 32'(rd_o), 32'hA5);

        write_both(4'd5, 8'h11);
        add = 4'd5; wd = 8'h22; we = 1'b1; re = 1'b1;
        cycle();
        idle();
        check("rdw_old", 32'(rd_o), 32'h11);
        check("rdw_new", 32'(rd_n), 32'h22);
        model[5] = 8'h22;
        read_both(4'd5, 8'h22, "after_rdw");

        add = 4'd13; wd = 8'h7F; we = 1'b1; re = 1'b0;
        cycle();
        idle();
        check("oor_wr_err", 32'({err_o, err_n}), 32'b11);
        check("oor_wr_rv", 32'(rv_o), 32'd0);
        add = 4'd13; re = 1'b1;
        cycle();
        idle();
        check("oor_rd_err", 32'({err_o, err_n}), 32'b11);
        check("oor_rd_data", 32'({rd_o, rd_n}), 32'h0);
        check("oor_rd_rv", 32'(rv_o), 32'd1);
        cycle();
        check("err_one_pulse", 32'(err_o), 32'd0);
        for (int a = 0; a < 12; a++) read_both(4'(a), model[a], "after_oor");

        write_both(4'd0, 8'hFF);
        read_both(4'd0, 8'hFF, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_rd", 32'(rd_o), 32'h0);
        check("async_rst_flags", 32'({rv_o, rdy_o, err_o}), 32'h0);
        cycle();
        cycle();
        rst = 1'b1;
        wait_ready(0, n);
        check("reclear_cycles", 32'(n), 32'd12);
        read_both(4'd0, 8'h00, "reclear_a0");
        read_both(4'd3, 8'h00, "reclear_a3");

        n = 0;
        while (!(rdy_c && rdy_d) && n < 40) begin
            cycle();
            n++;
        end
        check("def_ready", 32'({rdy_c, rdy_d}), 32'b11);
        add4 = 4'd15; wd4 = 4'hB; we4 = 1'b1; re4 = 1'b1;
        cycle();
        we4 = 1'b0; re4 = 1'b0;
        check("def_rdw_old", 32'(rd_c), 32'h0);
        check("def_rdw_new", 32'(rd_d), 32'hB);
        add4 = 4'd15; re4 = 1'b1;
        cycle();
        re4 = 1'b0;
        check("def_readback", 32'({rd_c, rd_d}), 32'hBB);
        cycle();
        check("def_no_err", 32'(err_cd_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
